arcade_input_mapper: RTL and testbench
======================================

# arcade_input_mapper

Parametrised player-input front end for the arcade cores. Decodes the hps_io `ps2_key` event stream into latched per-player key states, merges them with up to four MiSTer joysticks, applies screen-rotation remapping of directions, and delivers registered, per-player control vectors with stretched coin pulses. Sits between hps_io and the game core, replacing ad-hoc keyboard/joystick glue in each top level.

## Interface
- NUM_PLAYERS, 2, number of player channels (1..4)
- COIN_PULSE_CYCLES, 16'd6000, coin output high time in clk_sys cycles (≥1)
- AUTOFIRE_HALF, 20'd200000, autofire half-period in cycles (≥1; used only with macro)

- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick  in  16*NUM_PLAYERS  player p at [16p+15:16p]
- rotate  in  2  00/11 none, 01 CW, 10 CCW
- ctrl  out  8*NUM_PLAYERS  per player: [0] right [1] left [2] down [3] up [4] fire1 [5] fire2 [6] start [7] coin
- test  out  1  service/test key state

## Operation
- Joystick bits 0..7 use the same layout as `ctrl`; bit 8 = autofire hold (macro only); others ignored.
- Key event: cycle where ps2_key[10] != tog_q; tog_q <= ps2_key[10] every cycle. On event, matching key latch <= ps2_key[9].
- Key map P1: ext 75/72/6B/74 up/down/left/right; 14 (ext ignored) and 29 fire1; 11 fire2; 16 start; 2E coin. P2 (if NUM_PLAYERS≥2): 2D/2B/23/34 up/down/left/right; 1C fire1; 1B fire2; 1E start; 36 coin. 2C test. Non-arrow codes require ext=0 except 14. Unmapped codes: no change.
- Raw vector per player = key latches | joystick bits (players 3,4: joystick only).
- Rotation on raw directions: CW: up=left, down=right, left=down, right=up. CCW: up=right, down=left, left=up, right=down. Fire/start/coin unaffected. `rotate` sampled combinationally into the output register each cycle (may change anytime).
- Coin: rising edge of raw coin loads per-player counter with COIN_PULSE_CYCLES; coin out high while counter ≠ 0. Edges during an active pulse ignored (no extension, no queueing). Held coin never retriggers.

## Timing
- Reset: all key latches, counters, `ctrl`, `test` = 0; tog_q <= ps2_key[10] (no spurious event on release of reset).
- Joystick → `ctrl`: 1 cycle (registered output).
- Key event at edge N updates latch; `ctrl`/`test` reflect it after edge N+1.
- Coin: raw edge visible at edge N → `ctrl` coin high from edge N+1 for exactly COIN_PULSE_CYCLES cycles.
- Key press and joystick same cycle: OR, no priority. Press and release of same key on consecutive events: each applied in order, one per cycle.
- Reset mid-pulse: pulse aborted, coin low next cycle; latches cleared even if keys physically held (next make restores).

## Configuration
- ARCADE_INPUT_AUTOFIRE_EN defined: shared free-running counter toggles phase every AUTOFIRE_HALF cycles; per player, while joystick bit 8 held, fire1 out = raw fire1 | phase. Counter cleared, phase 0 on reset.
- Undefined: bit 8 ignored, no counter logic synthesised, AUTOFIRE_HALF unused.

## Structure
- Package arcade_input_pkg: ctrl bit-index localparams, scancode constants, rotate encoding enum.
- Sub-module coin_pulse_stretcher (edge detect + down-counter), one instance per player.

## Test plan
- Reset, then ps2_key toggle with {pressed=1, ext=1, 0x75}, rotate=00 -> ctrl[3]=1 two cycles later; release event -> ctrl[3]=0.
- rotate=01, joystick P1 = 0x0008 (up) -> ctrl[0] (right) =1, ctrl[3]=0 after 1 cycle; rotate=10 -> ctrl[1]=1.
- COIN_PULSE_CYCLES=4, joystick P2 bit7 held 10 cycles -> ctrl[15]=1 exactly 4 cycles, no retrigger; second press during pulse ignored.
- Key 0x14 with ext=1 and ext=0 both -> P1 fire1; 0x75 with ext=0 -> no change; unmapped 0x44 -> no change.
- Reset asserted mid coin pulse with key latch set -> all ctrl 0 next cycle; no event generated at reset release.
- With ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_HALF=3, joy bit8 held -> fire1 toggles every 3 cycles; without macro -> fire1 stays 0.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - control-bit indices, scancodes and rotation helper for arcade_input_mapper
package arcade_input_pkg;

  // Bit positions inside one player's 8-bit control vector (joystick bits 0..7 share this layout)
  localparam int CTRL_RIGHT = 0;
  localparam int CTRL_LEFT  = 1;
  localparam int CTRL_DOWN  = 2;
  localparam int CTRL_UP    = 3;
  localparam int CTRL_FIRE1 = 4;
  localparam int CTRL_FIRE2 = 5;
  localparam int CTRL_START = 6;
  localparam int CTRL_COIN  = 7;

  // Joystick bit that requests autofire on fire1
  localparam int JOY_AUTOFIRE = 8;

  // Player 1: arrows are extended codes, 0x14 is accepted with or without the extended prefix
  localparam logic [7:0] SC_P1_UP      = 8'h75;
  localparam logic [7:0] SC_P1_DOWN    = 8'h72;
  localparam logic [7:0] SC_P1_LEFT    = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT   = 8'h74;
  localparam logic [7:0] SC_P1_FIRE1_A = 8'h14;
  localparam logic [7:0] SC_P1_FIRE1_B = 8'h29;
  localparam logic [7:0] SC_P1_FIRE2   = 8'h11;
  localparam logic [7:0] SC_P1_START   = 8'h16;
  localparam logic [7:0] SC_P1_COIN    = 8'h2E;

  // Player 2: all non-extended
  localparam logic [7:0] SC_P2_UP      = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN    = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT    = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT   = 8'h34;
  localparam logic [7:0] SC_P2_FIRE1   = 8'h1C;
  localparam logic [7:0] SC_P2_FIRE2   = 8'h1B;
  localparam logic [7:0] SC_P2_START   = 8'h1E;
  localparam logic [7:0] SC_P2_COIN    = 8'h36;

  localparam logic [7:0] SC_TEST       = 8'h2C;

  typedef enum logic [1:0] {
    ROT_NONE     = 2'b00,
    ROT_CW       = 2'b01,
    ROT_CCW      = 2'b10,
    ROT_NONE_ALT = 2'b11
  } rotate_e;

  // Remap the four direction bits for a rotated screen; other bits pass through
  function automatic logic [7:0] rotate_dirs(input logic [7:0] raw, input rotate_e rot);
    logic [7:0] res;
    res = raw;
    case (rot)
      ROT_CW: begin
        res[CTRL_UP]    = raw[CTRL_LEFT];
        res[CTRL_DOWN]  = raw[CTRL_RIGHT];
        res[CTRL_LEFT]  = raw[CTRL_DOWN];
        res[CTRL_RIGHT] = raw[CTRL_UP];
      end
      ROT_CCW: begin
        res[CTRL_UP]    = raw[CTRL_RIGHT];
        res[CTRL_DOWN]  = raw[CTRL_LEFT];
        res[CTRL_LEFT]  = raw[CTRL_UP];
        res[CTRL_RIGHT] = raw[CTRL_DOWN];
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/coin_pulse_stretcher.sv
// rtl/coin_pulse_stretcher.sv - rising-edge triggered fixed-length coin pulse
module coin_pulse_stretcher #(
  parameter logic [15:0] PULSE_CYCLES = 16'd6000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin_active
);

  logic [15:0] count;
  logic        prev;

  // Load on a fresh rising edge only when idle; edges inside a pulse are dropped
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count <= '0;
      prev  <= 1'b0;
    end else begin
      prev <= coin_raw;
      if (coin_raw && !prev && (count == 16'd0)) begin
        count <= PULSE_CYCLES;
      end else if (count != 16'd0) begin
        count <= count - 16'd1;
      end
    end
  end

  assign coin_active = (count != 16'd0);

endmodule

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick merge, rotation and coin stretching; optional autofire via ARCADE_INPUT_AUTOFIRE_EN
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS       = 2,
  parameter logic [15:0] COIN_PULSE_CYCLES = 16'd6000,
  parameter logic [19:0] AUTOFIRE_HALF     = 20'd200000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [10:0]               ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic [1:0]                rotate,
  output logic [8*NUM_PLAYERS-1:0]  ctrl,
  output logic                      test
);

  logic       tog_q;
  logic       key_event;
  logic       key_pressed;
  logic       key_ext;
  logic [7:0] key_code;
  logic [7:0] key_p1;
  logic [7:0] key_p2;
  logic       key_test;
  logic       test_q;

  assign key_event   = (ps2_key[10] != tog_q);
  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_code    = ps2_key[7:0];

  // Track the toggle bit even in reset so releasing reset never looks like a new event
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
  end

  // Key latches: each event sets or clears the one key it names
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_p1   <= '0;
      key_p2   <= '0;
      key_test <= 1'b0;
    end else if (key_event) begin
      if (key_code == SC_P1_FIRE1_A) begin
        key_p1[CTRL_FIRE1] <= key_pressed;
      end else if (key_ext) begin
        case (key_code)
          SC_P1_UP:    key_p1[CTRL_UP]    <= key_pressed;
          SC_P1_DOWN:  key_p1[CTRL_DOWN]  <= key_pressed;
          SC_P1_LEFT:  key_p1[CTRL_LEFT]  <= key_pressed;
          SC_P1_RIGHT: key_p1[CTRL_RIGHT] <= key_pressed;
          default: ;
        endcase
      end else begin
        case (key_code)
          SC_P1_FIRE1_B: key_p1[CTRL_FIRE1] <= key_pressed;
          SC_P1_FIRE2:   key_p1[CTRL_FIRE2] <= key_pressed;
          SC_P1_START:   key_p1[CTRL_START] <= key_pressed;
          SC_P1_COIN:    key_p1[CTRL_COIN]  <= key_pressed;
          SC_P2_UP:      if (NUM_PLAYERS >= 2) key_p2[CTRL_UP]    <= key_pressed;
          SC_P2_DOWN:    if (NUM_PLAYERS >= 2) key_p2[CTRL_DOWN]  <= key_pressed;
          SC_P2_LEFT:    if (NUM_PLAYERS >= 2) key_p2[CTRL_LEFT]  <= key_pressed;
          SC_P2_RIGHT:   if (NUM_PLAYERS >= 2) key_p2[CTRL_RIGHT] <= key_pressed;
          SC_P2_FIRE1:   if (NUM_PLAYERS >= 2) key_p2[CTRL_FIRE1] <= key_pressed;
          SC_P2_FIRE2:   if (NUM_PLAYERS >= 2) key_p2[CTRL_FIRE2] <= key_pressed;
          SC_P2_START:   if (NUM_PLAYERS >= 2) key_p2[CTRL_START] <= key_pressed;
          SC_P2_COIN:    if (NUM_PLAYERS >= 2) key_p2[CTRL_COIN]  <= key_pressed;
          SC_TEST:       key_test <= key_pressed;
          default: ;
        endcase
      end
    end
  end

  // Service key is registered alongside the control vectors
  always_ff @(posedge clk_sys) begin
    if (reset) test_q <= 1'b0;
    else       test_q <= key_test;
  end

  assign test = test_q;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [19:0] af_count;
  logic        af_phase;

  // Shared free-running autofire square wave, half-period AUTOFIRE_HALF cycles
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_count <= '0;
      af_phase <= 1'b0;
    end else if (af_count == AUTOFIRE_HALF - 20'd1) begin
      af_count <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_count <= af_count + 20'd1;
    end
  end
`else
  localparam logic [19:0] AUTOFIRE_HALF_UNUSED = AUTOFIRE_HALF;
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [7:0] key_bits;
    logic [7:0] raw;
    logic [7:0] shaped;
    logic [7:0] ctrl_q;
    logic       coin_active;
    logic       joy_unused;

    if (p == 0) begin : g_keys_p1
      assign key_bits = key_p1;
    end else if (p == 1) begin : g_keys_p2
      assign key_bits = key_p2;
    end else begin : g_keys_none
      assign key_bits = '0;
    end

    assign raw        = key_bits | joystick[16*p +: 8];
    assign joy_unused = ^joystick[16*p+8 +: 8];

    coin_pulse_stretcher #(
      .PULSE_CYCLES(COIN_PULSE_CYCLES)
    ) u_coin (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .coin_raw   (raw[CTRL_COIN]),
      .coin_active(coin_active)
    );

    // Rotate directions, substitute the stretched coin, optionally overlay autofire
    always_comb begin
      shaped             = rotate_dirs(raw, rotate_e'(rotate));
      shaped[CTRL_COIN]  = coin_active;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      shaped[CTRL_FIRE1] = raw[CTRL_FIRE1] | (joystick[16*p+JOY_AUTOFIRE] & af_phase);
`endif
    end

    // Registered per-player control vector
    always_ff @(posedge clk_sys) begin
      if (reset) ctrl_q <= '0;
      else       ctrl_q <= shaped;
    end

    assign ctrl[8*p +: 8] = ctrl_q;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - self-checking bench for arcade_input_mapper
module tb_arcade_input_mapper;

  localparam int NP   = 2;
  localparam int COIN = 4;
  localparam int HALF = 3;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [31:0]   joystick;
  logic [1:0]    rotate;
  logic [15:0]   ctrl;
  logic          test;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: key set as a flat 17-entry array (16 = test key)
  logic [16:0] m_keys;
  logic        m_tog;
  int          m_coin_left [NP];
  logic        m_coin_prev [NP];
  int          m_af_edges;
  logic [15:0] m_ctrl;
  logic        m_test;

  typedef struct {
    logic [31:0] joy;
    logic [1:0]  rot;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  logic [7:0] codes[20];

  arcade_input_mapper #(
    .NUM_PLAYERS      (NP),
    .COIN_PULSE_CYCLES(16'd4),
    .AUTOFIRE_HALF    (20'd3)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joystick(joystick),
    .rotate  (rotate),
    .ctrl    (ctrl),
    .test    (test)
  );

  always #5 clk_sys = ~clk_sys;

  // Slot in the flat key array for a scancode: player*8+bit, 16 = test, -1 = unmapped
  function automatic int key_slot(input logic ext, input logic [7:0] code);
    if (code == 8'h14) return 4;
    if (ext) begin
      case (code)
        8'h75: return 3;
        8'h72: return 2;
        8'h6B: return 1;
        8'h74: return 0;
        default: return -1;
      endcase
    end
    case (code)
      8'h29: return 4;
      8'h11: return 5;
      8'h16: return 6;
      8'h2E: return 7;
      8'h2D: return 11;
      8'h2B: return 10;
      8'h23: return 9;
      8'h34: return 8;
      8'h1C: return 12;
      8'h1B: return 13;
      8'h1E: return 14;
      8'h36: return 15;
      8'h2C: return 16;
      default: return -1;
    endcase
  endfunction

  // Screen rotation described as "which physical direction feeds each output"
  function automatic logic [7:0] rot_model(input logic [7:0] r, input logic [1:0] rot);
    logic [7:0] o;
    o = r;
    if (rot == 2'b01) begin
      o[3] = r[1]; o[2] = r[0]; o[1] = r[2]; o[0] = r[3];
    end else if (rot == 2'b10) begin
      o[3] = r[0]; o[2] = r[1]; o[1] = r[3]; o[0] = r[2];
    end
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    logic [7:0] raw [NP];
    logic [7:0] e;
    int         s;
    for (int p = 0; p < NP; p++) raw[p] = joystick[16*p +: 8] | m_keys[8*p +: 8];
    if (reset) begin
      m_keys = '0;
      m_tog  = ps2_key[10];
      m_ctrl = '0;
      m_test = 1'b0;
      m_af_edges = 0;
      for (int p = 0; p < NP; p++) begin
        m_coin_left[p] = 0;
        m_coin_prev[p] = 1'b0;
      end
      return;
    end
    for (int p = 0; p < NP; p++) begin
      e = rot_model(raw[p], rotate);
      e[7] = (m_coin_left[p] > 0);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (joystick[16*p+8] && ((m_af_edges / HALF) % 2 == 1)) e[4] = 1'b1;
`endif
      m_ctrl[8*p +: 8] = e;
    end
    m_test = m_keys[16];
    for (int p = 0; p < NP; p++) begin
      if (m_coin_left[p] == 0 && raw[p][7] && !m_coin_prev[p]) m_coin_left[p] = COIN;
      else if (m_coin_left[p] > 0) m_coin_left[p]--;
      m_coin_prev[p] = raw[p][7];
    end
    m_af_edges++;
    if (ps2_key[10] != m_tog) begin
      s = key_slot(ps2_key[8], ps2_key[7:0]);
      if (s >= 0) m_keys[s] = ps2_key[9];
    end
    m_tog = ps2_key[10];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, DUT compared 1 time unit later
  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("model_out", {15'd0, test, ctrl}, {15'd0, m_test, m_ctrl});
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  int highs;
  int first_high;

  initial begin
    reset    = 1'b1;
    ps2_key  = '0;
    joystick = '0;
    rotate   = 2'b00;
    m_keys   = '0;
    m_tog    = 1'b0;
    m_ctrl   = '0;
    m_test   = 1'b0;
    m_af_edges = 0;
    for (int p = 0; p < NP; p++) begin
      m_coin_left[p] = 0;
      m_coin_prev[p] = 1'b0;
    end

    vecs[0]  = '{32'h0000_0008, 2'b00, 16'h0008};
    vecs[1]  = '{32'h0000_0008, 2'b01, 16'h0001};
    vecs[2]  = '{32'h0000_0008, 2'b10, 16'h0002};
    vecs[3]  = '{32'h0000_0008, 2'b11, 16'h0008};
    vecs[4]  = '{32'h0000_0001, 2'b01, 16'h0004};
    vecs[5]  = '{32'h0000_0001, 2'b10, 16'h0008};
    vecs[6]  = '{32'h0000_0070, 2'b01, 16'h0070};
    vecs[7]  = '{32'h0002_0004, 2'b01, 16'h0802};
    vecs[8]  = '{32'h0004_0000, 2'b10, 16'h0100};
    vecs[9]  = '{32'hFE00_FE00, 2'b00, 16'h0000};
    vecs[10] = '{32'h000F_0000, 2'b01, 16'h0F00};

    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h11, 8'h16, 8'h2E, 8'h2D,
              8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h1E, 8'h36, 8'h2C, 8'h44, 8'h00};

    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_ctrl", {16'd0, ctrl}, 32'd0);
    check("reset_test", {31'd0, test}, 32'd0);

    // Joystick + rotation table, one-cycle latency
    for (int i = 0; i < 11; i++) begin
      joystick = vecs[i].joy;
      rotate   = vecs[i].rot;
      tick();
      check($sformatf("vec%0d", i), {16'd0, ctrl}, {16'd0, vecs[i].exp});
    end
    joystick = '0;
    rotate   = 2'b00;
    tick();

    // Extended up arrow: latch at event edge, visible one edge later
    send_key(1'b1, 1'b1, 8'h75);
    check("up_latency", {31'd0, ctrl[3]}, 32'd0);
    tick();
    check("up_press", {31'd0, ctrl[3]}, 32'd1);
    send_key(1'b0, 1'b1, 8'h75);
    check("up_release_latency", {31'd0, ctrl[3]}, 32'd1);
    tick();
    check("up_release", {31'd0, ctrl[3]}, 32'd0);

    // 0x14 maps to fire1 regardless of the extended flag
    send_key(1'b1, 1'b1, 8'h14); tick();
    check("fire1_14_ext", {31'd0, ctrl[4]}, 32'd1);
    send_key(1'b0, 1'b1, 8'h14); tick();
    check("fire1_14_ext_rel", {31'd0, ctrl[4]}, 32'd0);
    send_key(1'b1, 1'b0, 8'h14); tick();
    check("fire1_14_noext", {31'd0, ctrl[4]}, 32'd1);
    send_key(1'b0, 1'b0, 8'h14); tick();

    // Arrow code without extended prefix and an unmapped code change nothing
    send_key(1'b1, 1'b0, 8'h75); tick();
    check("up_noext_ignored", {16'd0, ctrl}, 32'd0);
    send_key(1'b1, 1'b0, 8'h44); tick();
    check("unmapped_ignored", {15'd0, test, ctrl}, 32'd0);
    send_key(1'b1, 1'b0, 8'h2C); tick();
    check("test_key", {31'd0, test}, 32'd1);
    send_key(1'b0, 1'b0, 8'h2C);
    send_key(1'b1, 1'b0, 8'h1C); tick();
    check("p2_fire1", {31'd0, ctrl[12]}, 32'd1);
    send_key(1'b0, 1'b0, 8'h1C); tick();

    // Press and release on consecutive cycles: one cycle of up
    send_key(1'b1, 1'b1, 8'h75);
    send_key(1'b0, 1'b1, 8'h75);
    check("pulse_press", {31'd0, ctrl[3]}, 32'd1);
    tick();
    check("pulse_release", {31'd0, ctrl[3]}, 32'd0);
    repeat (2) tick();

    // Coin stretch on P2 joystick, with a re-press inside the pulse
    highs = 0;
    first_high = -1;
    joystick = 32'h0080_0000;
    for (int t = 1; t <= 12; t++) begin
      if (t == 3) joystick = 32'h0000_0000;
      if (t == 4) joystick = 32'h0080_0000;
      tick();
      if (ctrl[15]) begin
        highs++;
        if (first_high < 0) first_high = t;
      end
    end
    check("coin_high_cycles", highs, COIN);
    check("coin_first_high", first_high, 2);
    check("coin_held_no_retrigger", {31'd0, ctrl[15]}, 32'd0);
    joystick = '0;
    repeat (2) tick();

    // Reset in the middle of a coin pulse with latches set, toggle moved during reset
    send_key(1'b1, 1'b0, 8'h2E);
    send_key(1'b1, 1'b1, 8'h75);
    tick();
    check("pre_reset_latched", {24'd0, ctrl[7:0]}, 32'h88);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h75};
    tick();
    check("reset_mid_pulse", {15'd0, test, ctrl}, 32'd0);
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("no_event_after_reset", {15'd0, test, ctrl}, 32'd0);
    end

    // Autofire request on P1
    joystick = 32'h0000_0100;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      check($sformatf("autofire_t%0d", t), {31'd0, ctrl[4]}, {31'd0, ((t - 1) / HALF) % 2 == 1});
    end
`else
    for (int t = 1; t <= 9; t++) begin
      tick();
      check($sformatf("autofire_off_t%0d", t), {31'd0, ctrl[4]}, 32'd0);
    end
`endif
    joystick = '0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) joystick = $urandom;
      if ($urandom_range(0, 7) == 0) rotate = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0, 1: ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         codes[$urandom_range(0, 19)]};
        2:    ps2_key = {ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         codes[$urandom_range(0, 19)]};
        default: ;
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
